bram_l7_reader: RTL and testbench
=================================

# bram_l7_reader

Streaming read controller for the layer-7 feature-map BRAM bank.
- Drives both read ports of the 8-lane, 16-bit, 1024-deep dual-port bank: port 1 reads even words, port 2 reads odd words.
- Re-times the returned words into a valid/ready stream that feeds the layer-8 PE array.
- Holds write-enable low for the whole transfer; the external write/read port mux is outside this block.

## Interface
- N_LANES, 8, lanes per BRAM word (16 bits each)
- AW, 10, BRAM address width
- LW, 10, width of the length field in beats

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  transfer request pulse, sampled only in IDLE
- base_addr  in  AW  first word address, latched on start
- len  in  LW  number of beats; one beat = up to 2 words
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last beat handshakes
- bram_addr1  out  AW  port-1 read address
- bram_addr2  out  AW  port-2 read address
- bram_wr  out  1  constant 0
- bram_dout1  in  N_LANES*16  port-1 data, valid 1 cycle after the address
- bram_dout2  in  N_LANES*16  port-2 data, valid 1 cycle after the address
- out_data1  out  N_LANES*16  beat word 0
- out_data2  out  N_LANES*16  beat word 1
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts the beat
- out_last  out  1  marks the final beat

## Operation
- FSM states and transitions:
  - IDLE: start=1 → RUN, or DONE if len=0.
  - RUN: the last address is issued → DRAIN.
  - DRAIN: FIFO empty and nothing in flight → DONE.
  - DONE: → IDLE after 1 cycle; done=1 during DONE.
- Address issue:
  - Beat k presents addr1 = base_addr + 2k and addr2 = base_addr + 2k + 1, both modulo 2^AW.
  - Address wrap: 1023 → 0. Example: base 1023 gives addr1 = 1023, addr2 = 0.
- Issue rule: issue only if FIFO occupancy + in-flight < 3. The 1-cycle read latency means at most 1 read is in flight.
- Returned data:
  - Captured into a 3-entry FIFO with 2*N_LANES*16 data bits plus a last bit.
  - out_* is the FIFO head; a pop occurs on out_valid & out_ready.
- No backpressure gives 1 beat per cycle sustained.
- Under backpressure:
  - out_data1, out_data2 and out_last hold stable while out_valid=1 and out_ready=0.
  - No beat is dropped or duplicated.
- Start during busy is ignored. len is unsigned, so the maximum is 2^LW − 1 beats; addresses wrap freely.
- Idle outputs: bram_addr1 and bram_addr2 hold their last values; reset values are 0 and 1.

## Timing
- Start accepted at cycle 0.
- First address issued at cycle 1 (RUN).
- Data captured into the FIFO at the edge ending cycle 2.
- out_valid=1 in cycle 3. Latency is 3 cycles from start to the first beat.
- For len=N with out_ready held high:
  - The last beat appears in cycle N+2.
  - done is high in cycle N+3.
  - busy is low from cycle N+4.
- len=0: done is high in cycle 1 and busy is high in cycle 1 only. No address changes, no out_valid.
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data1=0, out_data2=0, bram_addr1=0, bram_addr2=1, bram_wr=0.
- Reset asserted mid-transfer:
  - All state clears asynchronously and the FIFO is emptied.
  - After release the block is in IDLE and the next start behaves as from power-up.

## Configuration
- BRAM_L7_RD_STALL_CNT_EN defined:
  - Adds output stall_cnt, 16 bits.
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - It saturates at 0xFFFF, clears on an accepted start, and resets to 0.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package bram_l7_pkg holds:
  - the FSM state enum: IDLE, RUN, DRAIN, DONE;
  - constant RD_LAT=1;
  - constant FIFO_DEPTH=3;
  - constant BRAM_DEPTH=1024;
  - the beat struct type {data1, data2, last}.
- One sub-module, bram_l7_rd_fifo: a synchronous 3-entry FIFO with push, pop, count, head output and async active-low reset.
- The FSM, address counter, in-flight tracking and optional stall counter live in the top module.

## Test plan
- Basic transfer:
  - Stimulus: BRAM model preloaded word[i] = {8{i[15:0]}}; base=0, len=4, out_ready=1.
  - Response: beats (0,1) (2,3) (4,5) (6,7) in cycles 3–6; out_last only on (6,7); done in cycle 7.
- Wrap-around:
  - Stimulus: base=1022, len=2.
  - Response: addresses (1022,1023) then (0,1); beats carry words 1022, 1023, 0, 1.
- Backpressure:
  - Stimulus: len=6, out_ready toggled 1,0,0,1,0,1,…
  - Response: all 6 beats in order, none lost or duplicated; outputs stable during stalls; FIFO never exceeds 3 entries.
- Zero length and busy:
  - Stimulus: len=0 start; then start pulsed again while busy during a len=8 run.
  - Response: the len=0 start gives done in cycle 1 and no out_valid. The second start during the len=8 run is ignored; exactly 8 beats are produced.
- Reset mid-transfer:
  - Stimulus: rst_n low at beat 3 of len=10; release; start base=100, len=1.
  - Response: outputs return to reset values immediately; the next transfer yields words (100,101) with out_last=1.
- Stall counter (BRAM_L7_RD_STALL_CNT_EN defined):
  - Stimulus: out_ready held 0 for 5 cycles after out_valid rises.
  - Response: stall_cnt=5; it clears on the next start.

Source files
------------

// File: rtl/bram_l7_pkg.sv
// Shared types and constants for the layer-7 BRAM streaming reader.
// The FSM states, the FIFO beat layout and the pointer helper all live here.
package bram_l7_pkg;

   localparam int N_LANES    = 8;
   localparam int DW         = N_LANES * 16;
   localparam int BRAM_DEPTH = 1024;
   localparam int AW         = $clog2(BRAM_DEPTH);
   localparam int LW         = 10;
   localparam int RD_LAT     = 1;
   localparam int FIFO_DEPTH = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DW-1:0] data1;
      logic [DW-1:0] data2;
      logic          last;
   } beat_t;

   // Ring-pointer advance for a depth that is not a power of two.
   function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] ptr);
      return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
   endfunction

endpackage

// File: rtl/bram_l7_rd_fifo.sv
// Three-entry beat FIFO between the BRAM read ports and the output stream.
// The head entry is presented combinationally; push into a full or pop from an empty FIFO is ignored.
module bram_l7_rd_fifo
   import bram_l7_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  beat_t      din,
   output beat_t      head,
   output logic [1:0] count
);

   beat_t      mem_reg [FIFO_DEPTH];
   logic [1:0] wr_ptr_reg;
   logic [1:0] rd_ptr_reg;
   logic [1:0] count_reg;
   logic       push_ok;
   logic       pop_ok;

   assign push_ok = push && (count_reg != 2'(FIFO_DEPTH));
   assign pop_ok  = pop && (count_reg != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (push_ok) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 2'd0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= fifo_ptr_inc(wr_ptr_reg);
         end
         if (pop_ok) begin
            rd_ptr_reg <= fifo_ptr_inc(rd_ptr_reg);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/bram_l7_reader.sv
// Streaming read controller for the layer-7 feature-map BRAM: even words on port 1, odd on port 2.
// Optional stall counter output is enabled by defining BRAM_L7_RD_STALL_CNT_EN.
module bram_l7_reader
   import bram_l7_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] bram_addr1,
   output logic [AW-1:0] bram_addr2,
   output logic          bram_wr,
   input  logic [DW-1:0] bram_dout1,
   input  logic [DW-1:0] bram_dout2,
   output logic [DW-1:0] out_data1,
   output logic [DW-1:0] out_data2,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last
`ifdef BRAM_L7_RD_STALL_CNT_EN
   ,
   output logic [15:0]   stall_cnt
`endif
);

   state_t        state_reg;
   state_t        state_next;
   logic [AW-1:0] addr1_reg;
   logic [AW-1:0] addr2_reg;
   logic [LW-1:0] rem_reg;
   logic          inflight_reg;
   logic          inflight_last_reg;

   logic          start_acc;
   logic          issue;
   logic          last_issue;
   logic          pop;
   logic [2:0]    occ;
   logic [1:0]    fifo_count;
   beat_t         fifo_din;
   beat_t         fifo_head;

   assign start_acc  = (state_reg == IDLE) && start;
   // Reserve a FIFO slot for every read in flight so a returning word always has room.
   assign occ        = {1'b0, fifo_count} + {2'b00, inflight_reg};
   assign issue      = (state_reg == RUN) && (occ < 3'(FIFO_DEPTH));
   assign last_issue = issue && (rem_reg == LW'(1));
   assign pop        = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_issue) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Leave as the final beat is accepted so done lands one cycle after it.
            if (!inflight_reg && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
               state_next = DONE;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr1_reg         <= '0;
         addr2_reg         <= AW'(1);
         rem_reg           <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
      end else begin
         if (start_acc && (len != '0)) begin
            addr1_reg <= base_addr;
            addr2_reg <= base_addr + AW'(1);
            rem_reg   <= len;
         end else if (issue) begin
            addr1_reg <= addr1_reg + AW'(2);
            addr2_reg <= addr2_reg + AW'(2);
            rem_reg   <= rem_reg - LW'(1);
         end
         inflight_reg      <= issue;
         inflight_last_reg <= last_issue;
      end
   end

   assign fifo_din = '{data1: bram_dout1, data2: bram_dout2, last: inflight_last_reg};

   bram_l7_rd_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight_reg),
      .pop   (pop),
      .din   (fifo_din),
      .head  (fifo_head),
      .count (fifo_count)
   );

   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign bram_addr1 = addr1_reg;
   assign bram_addr2 = addr2_reg;
   assign bram_wr    = 1'b0;
   assign out_valid  = (fifo_count != 2'd0);
   assign out_data1  = fifo_head.data1;
   assign out_data2  = fifo_head.data2;
   assign out_last   = out_valid && fifo_head.last;

`ifdef BRAM_L7_RD_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= 16'd0;
      end else if (start_acc) begin
         stall_cnt_reg <= 16'd0;
      end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_bram_l7_reader.sv
// Scoreboard bench for bram_l7_reader: stimulus pushes expected beats, a monitor pops on each handshake.
// Covers reset, basic, wrap, backpressure, zero-length, busy restart, mid-transfer reset and the optional stall counter.
module tb_bram_l7_reader;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [9:0]   base_addr;
   logic [9:0]   len;
   logic         busy;
   logic         done;
   logic [9:0]   bram_addr1;
   logic [9:0]   bram_addr2;
   logic         bram_wr;
   logic [127:0] bram_dout1 = '0;
   logic [127:0] bram_dout2 = '0;
   logic [127:0] out_data1;
   logic [127:0] out_data2;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
`ifdef BRAM_L7_RD_STALL_CNT_EN
   logic [15:0]  stall_cnt;
`endif

   typedef struct {
      logic [127:0] d1;
      logic [127:0] d2;
      logic         last;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   bram_l7_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .bram_addr1 (bram_addr1),
      .bram_addr2 (bram_addr2),
      .bram_wr    (bram_wr),
      .bram_dout1 (bram_dout1),
      .bram_dout2 (bram_dout2),
      .out_data1  (out_data1),
      .out_data2  (out_data2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last)
`ifdef BRAM_L7_RD_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   // Preloaded BRAM contents: word[i] = {8{i[15:0]}}
   function automatic logic [127:0] word(input int a);
      logic [15:0] v;
      v = 16'(a % 1024);
      return {8{v}};
   endfunction

   always @(posedge clk) begin
      bram_dout1 <= word(int'(bram_addr1));
      bram_dout2 <= word(int'(bram_addr2));
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // mode 0: always ready; 1: pattern 1,0,0,1,0,1; 2: not ready before cycle 8
   function automatic logic ready_for(input int mode, input int cyc);
      case (mode)
         1:       return (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
         2:       return cyc >= 8;
         default: return 1'b1;
      endcase
   endfunction

   // Scoreboard monitor
   logic         hold_pending = 1'b0;
   logic [127:0] hold_d1, hold_d2;
   logic         hold_last;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data1", out_data1, hold_d1);
            chk("hold_data2", out_data2, hold_d2);
            chk("hold_last", out_last, hold_last);
         end
         if (out_valid && out_ready) begin
            chk("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("beat_data1", out_data1, e.d1);
               chk("beat_data2", out_data2, e.d2);
               chk("beat_last", out_last, e.last);
            end
         end
         hold_pending = out_valid && !out_ready;
         hold_d1      = out_data1;
         hold_d2      = out_data2;
         hold_last    = out_last;
      end
   end

   task automatic run_xfer(input int b, input int n, input int mode, input int restart_cyc,
                           input int abort_cyc, output int done_cyc, output int first_v,
                           output int last_cyc, output logic [9:0] a1_c1, output logic [9:0] a2_c1,
                           output logic [9:0] a1_c2, output logic [9:0] a2_c2);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{d1: word(b + 2*k), d2: word(b + 2*k + 1), last: (k == n - 1)});
      end
      done_cyc = -1; first_v = -1; last_cyc = -1;
      a1_c1 = '0; a2_c1 = '0; a1_c2 = '0; a2_c2 = '0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'(b); len = 10'(n); out_ready = ready_for(mode, 0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         if (cyc > 1) begin
            @(posedge clk); #1;
         end
         out_ready = ready_for(mode, cyc);
         start = (cyc == restart_cyc);
         if (cyc == restart_cyc) begin
            base_addr = 10'd500; len = 10'd2;
         end
         if (cyc == abort_cyc) begin
            rst_n = 1'b0;
            return;
         end
         @(negedge clk);
         if (cyc == 1) begin
            a1_c1 = bram_addr1; a2_c1 = bram_addr2;
            chk("bram_wr_low", bram_wr, 1'b0);
         end
         if (cyc == 2) begin
            a1_c2 = bram_addr1; a2_c2 = bram_addr2;
         end
         if (out_valid && first_v < 0) first_v = cyc;
         if (out_valid && out_ready && out_last) last_cyc = cyc;
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      chk("done_seen", done_cyc >= 0, 1'b1);
      if (done_cyc >= 0) begin
         chk("busy_in_done", busy, 1'b1);
         @(posedge clk);
         @(negedge clk);
         chk("busy_after_done", busy, 1'b0);
         chk("done_one_cycle", done, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, f, l;
      logic [9:0] a1, b1, a2, b2, p1, p2;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_data1", out_data1, 128'd0);
      chk("rst_data2", out_data2, 128'd0);
      chk("rst_addr1", bram_addr1, 10'd0);
      chk("rst_addr2", bram_addr2, 10'd1);
      chk("rst_wr", bram_wr, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic transfer
      run_xfer(0, 4, 0, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("basic_first_valid", f, 3);
      chk("basic_last_cyc", l, 6);
      chk("basic_done_cyc", d, 7);
      chk("basic_all_beats", exp_q.size(), 0);
      $display("basic: done_cyc=%0d first_valid=%0d last_cyc=%0d", d, f, l);

      // Wrap-around
      run_xfer(1022, 2, 0, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("wrap_addr1_c1", a1, 10'd1022);
      chk("wrap_addr2_c1", b1, 10'd1023);
      chk("wrap_addr1_c2", a2, 10'd0);
      chk("wrap_addr2_c2", b2, 10'd1);
      chk("wrap_done_cyc", d, 5);
      $display("wrap: addr c1=(%0d,%0d) c2=(%0d,%0d)", a1, b1, a2, b2);

      run_xfer(1023, 1, 0, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("top_addr1", a1, 10'd1023);
      chk("top_addr2", b1, 10'd0);
      chk("top_done_cyc", d, 4);
      $display("base1023: addr=(%0d,%0d) done_cyc=%0d", a1, b1, d);

      // Backpressure
      run_xfer(10, 6, 1, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("bp_all_beats", exp_q.size(), 0);
      $display("backpressure: done_cyc=%0d", d);

      // Zero length
      p1 = bram_addr1; p2 = bram_addr2;
      run_xfer(300, 0, 0, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("zero_done_cyc", d, 1);
      chk("zero_no_valid", f, -1);
      chk("zero_addr1_held", a1, p1);
      chk("zero_addr2_held", b1, p2);
      $display("zero_len: done_cyc=%0d", d);

      // Start while busy is ignored
      run_xfer(20, 8, 0, 3, 0, d, f, l, a1, b1, a2, b2);
      chk("busy_first_valid", f, 3);
      chk("busy_last_cyc", l, 10);
      chk("busy_done_cyc", d, 11);
      chk("busy_all_beats", exp_q.size(), 0);
      repeat (5) @(posedge clk);
      $display("restart_ignored: done_cyc=%0d", d);

      // Reset mid-transfer
      run_xfer(200, 10, 0, 0, 6, d, f, l, a1, b1, a2, b2);
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_last", out_last, 1'b0);
      chk("mid_rst_data1", out_data1, 128'd0);
      chk("mid_rst_data2", out_data2, 128'd0);
      chk("mid_rst_addr1", bram_addr1, 10'd0);
      chk("mid_rst_addr2", bram_addr2, 10'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_xfer(100, 1, 0, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("post_rst_first_valid", f, 3);
      chk("post_rst_last_cyc", l, 3);
      chk("post_rst_done_cyc", d, 4);
      chk("post_rst_all_beats", exp_q.size(), 0);
      $display("post_reset: done_cyc=%0d", d);

`ifdef BRAM_L7_RD_STALL_CNT_EN
      run_xfer(50, 1, 2, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("stall_cnt_value", stall_cnt, 16'd5);
      $display("stall: stall_cnt=%0d", stall_cnt);
      run_xfer(0, 0, 0, 0, 0, d, f, l, a1, b1, a2, b2);
      chk("stall_cnt_cleared", stall_cnt, 16'd0);
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
